// File: rtl/nerv_arb_pkg.sv
// Shared types and constants for the nerv single-port memory arbiter.
package nerv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_ISSUE = 2'd0,
        ARB_DMEM  = 2'd1,
        ARB_IMEM  = 2'd2
    } arb_state_e;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam int          TIMEOUT_W = 8;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/nerv_arb_watchdog.sv
// Counts consecutive memory wait cycles and flags the cycle in which an access must be aborted.
module nerv_arb_watchdog
    import nerv_arb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LIMIT - 1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // Expiry fires on the LIMIT-th wait cycle; a ready in that cycle suppresses it.
    assign expire_o = wait_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nerv_mem_arbiter.sv
// Serialises nerv fetch and load/store requests onto one variable-latency memory port, data access first.
module nerv_mem_arbiter
    import nerv_arb_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        stall_in,
    output logic        stall,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    arb_state_e  state_q, state_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        oor_q, oor_d;
    logic [31:0] imem_data_q, imem_data_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        bus_err_q, bus_err_d;
    logic        advance;
    logic        expire;
    logic        mem_wait;

    function automatic logic addr_oor(input logic [31:0] a);
        return (a >> MEM_ADDR_WIDTH) != 32'd0;
    endfunction

    assign mem_wait = mem_valid_q && !mem_ready;

    nerv_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clock),
        .rst_n   (resetn),
        .wait_i  (mem_wait),
        .clear_i (advance),
        .expire_o(expire)
    );

    always_comb begin
        state_d      = state_q;
        iaddr_d      = iaddr_q;
        oor_d        = oor_q;
        imem_data_d  = imem_data_q;
        dmem_rdata_d = dmem_rdata_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        bus_err_d    = bus_err_q;
        advance      = 1'b0;

        case (state_q)
            ARB_ISSUE: begin
                if (!stall_in) begin
                    iaddr_d = imem_addr;
                    if (dmem_valid) begin
                        state_d     = ARB_DMEM;
                        oor_d       = addr_oor(dmem_addr);
                        mem_valid_d = !addr_oor(dmem_addr);
                        mem_addr_d  = word_addr(dmem_addr);
                        mem_wstrb_d = dmem_wstrb;
                        mem_wdata_d = dmem_wdata;
                    end else begin
                        state_d     = ARB_IMEM;
                        oor_d       = 1'b0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = word_addr(imem_addr);
                        mem_wstrb_d = 4'b0000;
                    end
                end
            end

            ARB_DMEM: begin
                // An out-of-range access never reaches the bus and is reported like a timeout.
                if (oor_q || expire) begin
                    bus_err_d    = 1'b1;
                    dmem_rdata_d = '0;
                    advance      = 1'b1;
                end else if (mem_ready) begin
                    dmem_rdata_d = (mem_wstrb_q == 4'b0000) ? mem_rdata : '0;
                    advance      = 1'b1;
                end
                if (advance) begin
                    state_d     = ARB_IMEM;
                    oor_d       = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = word_addr(iaddr_q);
                    mem_wstrb_d = 4'b0000;
                end
            end

            ARB_IMEM: begin
                if (mem_ready) begin
                    imem_data_d = mem_rdata;
                    advance     = 1'b1;
                end else if (expire) begin
                    imem_data_d = NOP_INSN;
                    bus_err_d   = 1'b1;
                    advance     = 1'b1;
                end
                if (advance) begin
                    state_d     = ARB_ISSUE;
                    mem_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ARB_ISSUE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_ISSUE;
            iaddr_q      <= '0;
            oor_q        <= 1'b0;
            imem_data_q  <= '0;
            dmem_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            iaddr_q      <= iaddr_d;
            oor_q        <= oor_d;
            imem_data_q  <= imem_data_d;
            dmem_rdata_q <= dmem_rdata_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall      = stall_in | (state_q != ARB_ISSUE);
    assign imem_data  = imem_data_q;
    assign dmem_rdata = dmem_rdata_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign bus_err    = bus_err_q;

endmodule
